// File: rtl/cmd_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_link_pkg
//  Description : Shared constants for the command link. It holds the FSM
//                state encodings, the command type codes and the link words
//                used by the framer and the receive-side deframer.
//  Revision    : 1.0  initial release
// ============================================================================
package cmd_link_pkg;

    // One-hot transmit framer states
    typedef enum logic [5:0] {
        ST_IDLE = 6'b000001,
        ST_SOF  = 6'b000010,
        ST_HDR  = 6'b000100,
        ST_SEQ  = 6'b001000,
        ST_CSUM = 6'b010000,
        ST_GAP  = 6'b100000
    } cmd_state_e;

    // Valid command type codes; 00 and 11 are rejected
    localparam logic [1:0]  CMD_TYPE_ACK  = 2'b01;
    localparam logic [1:0]  CMD_TYPE_SHDN = 2'b10;

    // Link words (K28.5 sits in the high byte of IDLE and SOF)
    localparam logic [15:0] IDLE_WORD = 16'hBC50;
    localparam logic [15:0] SOF_WORD  = 16'hBC1C;
    localparam logic [7:0]  CMD_MAGIC = 8'hA5;
    localparam logic [7:0]  SEQ_TAG   = 8'h5A;

    // Per-byte K flags, bit 1 is the high byte
    localparam logic [1:0]  K_HIGH = 2'b10;
    localparam logic [1:0]  K_NONE = 2'b00;

    // True for the two command types that produce a frame
    function automatic logic cmd_type_valid(input logic [1:0] t);
        return (t == CMD_TYPE_ACK) || (t == CMD_TYPE_SHDN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_tx_framer
//  Description : Command-link transmitter. It serialises a 4-word command
//                frame (SOF, header, sequence, checksum) onto a 16-bit GTX TX
//                lane and then forces an idle gap. It reports completion,
//                rejected types and link-loss aborts as one-cycle pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module cmd_tx_framer
    import cmd_link_pkg::*;
#(
    parameter int unsigned MIN_GAP = 4   // idle words forced after each frame (1..15)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_tx_i,
    input  logic [1:0]  cmd_type_i,
    input  logic        link_up_i,
    output logic        cmd_done_o,
    output logic        cmd_err_o,
    output logic        cmd_abort_o,
    output logic        busy_o,
    output logic [7:0]  seq_num_o,
    output logic [15:0] tx_data_o,
    output logic [1:0]  tx_charisk_o
);

    localparam logic [3:0] c_GAP_LAST = 4'(MIN_GAP - 1);

    cmd_state_e  state_q;
    logic        armed_q;
    logic        done_pend_q;   // frame finished normally; pulse done on first gap word
    logic [1:0]  type_q;
    logic [3:0]  gap_cnt_q;
    logic [7:0]  seq_num_q;
    logic [15:0] tx_data_q;
    logic [1:0]  tx_charisk_q;
    logic        cmd_done_q;
    logic        cmd_err_q;
    logic        cmd_abort_q;
    logic        busy_q;

    logic        w_accept;
    logic [15:0] w_hdr_word;
    logic [15:0] w_seq_word;
    logic [15:0] w_csum_word;

    assign w_accept    = (state_q == ST_IDLE) && link_up_i && armed_q && cmd_tx_i;
    assign w_hdr_word  = {CMD_MAGIC, 6'b000000, type_q};
    assign w_seq_word  = {seq_num_q, SEQ_TAG};
    assign w_csum_word = w_hdr_word + w_seq_word;   // carry deliberately dropped

    // Framer FSM: each state registers the word it owns on the following edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b1;
            done_pend_q  <= 1'b0;
            type_q       <= 2'b00;
            gap_cnt_q    <= 4'd0;
            seq_num_q    <= 8'd0;
            tx_data_q    <= IDLE_WORD;
            tx_charisk_q <= K_HIGH;
            cmd_done_q   <= 1'b0;
            cmd_err_q    <= 1'b0;
            cmd_abort_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cmd_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_abort_q <= 1'b0;

            // Any cycle with the request low re-arms; accept below needs it high
            if (!cmd_tx_i) begin
                armed_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    tx_data_q    <= IDLE_WORD;
                    tx_charisk_q <= K_HIGH;
                    if (w_accept) begin
                        armed_q <= 1'b0;
                        if (cmd_type_valid(cmd_type_i)) begin
                            type_q  <= cmd_type_i;
                            busy_q  <= 1'b1;
                            state_q <= ST_SOF;
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                end

                ST_SOF, ST_HDR, ST_SEQ, ST_CSUM: begin
                    if (!link_up_i) begin
                        // Link lost mid-frame: idle the lane and drain through the gap
                        tx_data_q    <= IDLE_WORD;
                        tx_charisk_q <= K_HIGH;
                        cmd_abort_q  <= 1'b1;
                        gap_cnt_q    <= 4'd0;
                        state_q      <= ST_GAP;
                    end else begin
                        tx_charisk_q <= K_NONE;
                        case (state_q)
                            ST_SOF: begin
                                tx_data_q    <= SOF_WORD;
                                tx_charisk_q <= K_HIGH;
                                state_q      <= ST_HDR;
                            end
                            ST_HDR: begin
                                tx_data_q <= w_hdr_word;
                                state_q   <= ST_SEQ;
                            end
                            ST_SEQ: begin
                                tx_data_q <= w_seq_word;
                                state_q   <= ST_CSUM;
                            end
                            default: begin
                                tx_data_q   <= w_csum_word;
                                done_pend_q <= 1'b1;
                                gap_cnt_q   <= 4'd0;
                                state_q     <= ST_GAP;
                            end
                        endcase
                    end
                end

                ST_GAP: begin
                    tx_data_q    <= IDLE_WORD;
                    tx_charisk_q <= K_HIGH;
                    if (done_pend_q) begin
                        cmd_done_q  <= 1'b1;
                        seq_num_q   <= seq_num_q + 8'd1;
                        done_pend_q <= 1'b0;
                    end
                    if (gap_cnt_q == c_GAP_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end

                default: begin
                    tx_data_q    <= IDLE_WORD;
                    tx_charisk_q <= K_HIGH;
                    busy_q       <= 1'b0;
                    done_pend_q  <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_done_o   = cmd_done_q;
    assign cmd_err_o    = cmd_err_q;
    assign cmd_abort_o  = cmd_abort_q;
    assign busy_o       = busy_q;
    assign seq_num_o    = seq_num_q;
    assign tx_data_o    = tx_data_q;
    assign tx_charisk_o = tx_charisk_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmd_tx_framer
//  Description : Scoreboard bench for cmd_tx_framer. Stimulus pushes the
//                expected frame words and pulse events; a monitor pops and
//                compares whenever the lane carries a non-idle word or a
//                pulse output fires.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cmd_tx_framer;

    localparam int MIN_GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_tx_i = 1'b0;
    logic [1:0]  cmd_type_i = 2'b00;
    logic        link_up_i = 1'b0;
    logic        cmd_done_o;
    logic        cmd_err_o;
    logic        cmd_abort_o;
    logic        busy_o;
    logic [7:0]  seq_num_o;
    logic [15:0] tx_data_o;
    logic [1:0]  tx_charisk_o;

    cmd_tx_framer #(.MIN_GAP(MIN_GAP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_tx_i     (cmd_tx_i),
        .cmd_type_i   (cmd_type_i),
        .link_up_i    (link_up_i),
        .cmd_done_o   (cmd_done_o),
        .cmd_err_o    (cmd_err_o),
        .cmd_abort_o  (cmd_abort_o),
        .busy_o       (busy_o),
        .seq_num_o    (seq_num_o),
        .tx_data_o    (tx_data_o),
        .tx_charisk_o (tx_charisk_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int idle_run = 100;
    logic [17:0] exp_words[$];   // {data, charisk}
    logic [9:0]  exp_evts[$];    // {code, seq_num}: 1=done 2=err 3=abort

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [15:0] hdr_w(input logic [1:0] t);
        return {8'hA5, 6'b000000, t};
    endfunction

    function automatic logic [15:0] seq_w(input logic [7:0] s);
        return {s, 8'h5A};
    endfunction

    // Queue a full valid frame carrying sequence number s, and its done pulse
    task automatic push_frame(input logic [1:0] t, input logic [7:0] s);
        logic [15:0] csum;
        csum = hdr_w(t) + seq_w(s);
        exp_words.push_back({16'hBC1C, 2'b10});
        exp_words.push_back({hdr_w(t), 2'b00});
        exp_words.push_back({seq_w(s), 2'b00});
        exp_words.push_back({csum, 2'b00});
        exp_evts.push_back({2'd1, s + 8'd1});
    endtask

    task automatic request(input logic [1:0] t, input int hold);
        @(negedge clk);
        cmd_type_i = t;
        cmd_tx_i   = 1'b1;
        repeat (hold) @(negedge clk);
        cmd_tx_i = 1'b0;
    endtask

    task automatic wait_idle();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            if (!busy_o) break;
            @(negedge clk);
        end
        if (busy_o) fail_now("wait_idle_timeout");
    endtask

    task automatic wait_word(input logic [15:0] w, input string name);
        for (int i = 0; i < 20; i++) begin
            if (tx_data_o == w) break;
            @(negedge clk);
        end
        if (tx_data_o != w) fail_now(name);
    endtask

    // Monitor: compare lane words and pulse events against the scoreboard
    initial begin
        int n;
        logic [1:0] code;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if ({tx_data_o, tx_charisk_o} === {16'hBC50, 2'b10}) begin
                    idle_run++;
                end else begin
                    if (tx_data_o == 16'hBC1C) begin
                        check("gap_before_sof", 32'(idle_run >= MIN_GAP), 32'd1);
                        idle_run = 0;
                    end
                    if (exp_words.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %h_%b expected idle", tx_data_o, tx_charisk_o);
                    end else begin
                        check("frame_word", {14'd0, tx_data_o, tx_charisk_o}, {14'd0, exp_words.pop_front()});
                    end
                end
                n = int'(cmd_done_o) + int'(cmd_err_o) + int'(cmd_abort_o);
                if (n > 1) fail_now("pulse_exclusive");
                if (n == 1) begin
                    code = cmd_done_o ? 2'd1 : (cmd_err_o ? 2'd2 : 2'd3);
                    if (exp_evts.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: got code %0d seq %h expected none", code, seq_num_o);
                    end else begin
                        check("pulse_event", {22'd0, code, seq_num_o}, {22'd0, exp_evts.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s;
        logic [1:0] t;

        // Reset state
        #12;
        check("rst_tx_data", tx_data_o, 16'hBC50);
        check("rst_charisk", tx_charisk_o, 2'b10);
        check("rst_seq", seq_num_o, 8'h00);
        check("rst_busy", busy_o, 1'b0);
        check("rst_pulses", {cmd_done_o, cmd_err_o, cmd_abort_o}, 3'b000);
        @(negedge clk);
        rst_n     = 1'b1;
        link_up_i = 1'b1;
        repeat (2) @(negedge clk);

        // 1: held request gives exactly one frame
        exp_words.push_back({16'hBC1C, 2'b10});
        exp_words.push_back({16'hA501, 2'b00});
        exp_words.push_back({16'h005A, 2'b00});
        exp_words.push_back({16'hA55B, 2'b00});
        exp_evts.push_back({2'd1, 8'h01});
        request(2'b01, 20);
        check("t1_busy", busy_o, 1'b0);
        check("t1_seq", seq_num_o, 8'h01);
        check("t1_idle", tx_data_o, 16'hBC50);

        // 2: SHUTDOWN ACK after a one-cycle low
        exp_words.push_back({16'hBC1C, 2'b10});
        exp_words.push_back({16'hA502, 2'b00});
        exp_words.push_back({16'h015A, 2'b00});
        exp_words.push_back({16'hA65C, 2'b00});
        exp_evts.push_back({2'd1, 8'h02});
        request(2'b10, 2);
        wait_idle();
        check("t2_seq", seq_num_o, 8'h02);

        // 3: invalid type is rejected
        exp_evts.push_back({2'd2, 8'h02});
        request(2'b11, 1);
        for (int i = 0; i < 3; i++) begin
            check("t3_busy", busy_o, 1'b0);
            check("t3_idle", tx_data_o, 16'hBC50);
            @(negedge clk);
        end
        check("t3_seq", seq_num_o, 8'h02);

        // Requests with the link down are ignored
        link_up_i  = 1'b0;
        cmd_type_i = 2'b01;
        cmd_tx_i   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("linkdown_busy", busy_o, 1'b0);
        end
        cmd_tx_i = 1'b0;
        @(negedge clk);
        link_up_i = 1'b1;
        @(negedge clk);

        // 4: link drop while HDR is on the lane aborts the frame
        exp_words.push_back({16'hBC1C, 2'b10});
        exp_words.push_back({16'hA501, 2'b00});
        exp_evts.push_back({2'd3, 8'h02});
        request(2'b01, 1);
        wait_word(16'hA501, "t4_hdr_timeout");
        link_up_i = 1'b0;
        @(negedge clk);
        check("t4_abort_word", tx_data_o, 16'hBC50);
        check("t4_no_done", cmd_done_o, 1'b0);
        link_up_i = 1'b1;
        wait_idle();
        check("t4_busy", busy_o, 1'b0);
        check("t4_seq", seq_num_o, 8'h02);
        push_frame(2'b01, 8'h02);
        request(2'b01, 1);
        wait_idle();
        check("t4_resend_seq", seq_num_o, 8'h03);

        // 5: 256 back-to-back requests wrap the sequence number
        s = 8'h03;
        for (int i = 0; i < 256; i++) begin
            t = (i % 2 == 0) ? 2'b01 : 2'b10;
            push_frame(t, s);
            request(t, 1);
            wait_idle();
            s = s + 8'd1;
        end
        check("t5_seq_wrap", seq_num_o, 8'h03);

        // 6: reset during the SEQ word
        exp_words.push_back({16'hBC1C, 2'b10});
        exp_words.push_back({16'hA502, 2'b00});
        exp_words.push_back({16'h035A, 2'b00});
        request(2'b10, 1);
        wait_word(16'h035A, "t6_seq_timeout");
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_tx_data", tx_data_o, 16'hBC50);
        check("t6_charisk", tx_charisk_o, 2'b10);
        check("t6_seq", seq_num_o, 8'h00);
        check("t6_busy", busy_o, 1'b0);
        check("t6_pulses", {cmd_done_o, cmd_err_o, cmd_abort_o}, 3'b000);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_after_tx", tx_data_o, 16'hBC50);
        check("t6_after_busy", busy_o, 1'b0);

        check("words_drained", exp_words.size(), 0);
        check("events_drained", exp_evts.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
